mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates two requesters for the single-port 8-bit data Memory: port 0 is the CPU controller/datapath load-store path; port 1 is a DMA/program-loader master.
- Serialises their accesses onto the memory's memread/memwrite/address/writedata/readdata interface.
- Owns the memory's one-cycle synchronous-read latency and returns read data to the correct requester with a valid pulse.
- Sits between the CPU datapath, the loader, and the Memory instance in the CPU top level.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-low (rst=0 resets).
- req0  input  1  port 0 (CPU) request.
- we0  input  1  port 0 write (1) / read (0).
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- gnt0  output  1  port 0 grant pulse; request accepted.
- rvalid0  output  1  port 0 read data valid pulse.
- rdata0  output  DATA_W  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above, for port 1 (DMA/loader).
- mem_memread  output  1  to Memory memread.
- mem_memwrite  output  1  to Memory memwrite.
- mem_address  output  ADDR_W  to Memory address.
- mem_writedata  output  DATA_W  to Memory writedata.
- mem_readdata  input  DATA_W  from Memory readdata; registered inside Memory.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; owner=0; last_owner=1; latched addr/data/we=0.
  - All outputs 0. Any in-flight transaction is dropped; no gnt or rvalid follows reset release.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any reqN is high on a rising edge, pick a winner per the arbitration policy.
  - Latch the winner's we/addr/wdata, set owner, go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (exactly one cycle):
  - gnt[owner]=1.
  - mem_address/mem_writedata driven from the latched registers.
  - mem_memwrite=latched_we; mem_memread=!latched_we.
  - Next state: write -> IDLE; read -> RESP.
- RESP (exactly one cycle):
  - rvalid[owner]=1; rdata[owner]=mem_readdata.
  - The non-owner rdata is held at 0. Next state: IDLE.
- Memory-side outputs are derived only from state and registers, so they are glitch-free.
- Outside ISSUE: mem_memread=mem_memwrite=0; mem_address/mem_writedata hold their latched values.
- Latency from the request edge:
  - gnt in the next cycle.
  - Write committed at the end of the gnt cycle.
  - Read data on rvalid two cycles after the request edge.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt.
  - Dropping req before it is sampled in IDLE withdraws the request; no gnt.
  - If req is still high in the IDLE cycle after completion, it is a new request.
  - Requests arriving during ISSUE/RESP are ignored until IDLE.
- gnt0 and gnt1 are never high together; likewise rvalid0 and rvalid1.
- last_owner updates to owner on every IDLE->ISSUE transition.
- Both ports requesting the same address: serialised; the later reader sees the earlier writer's data.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both ports request in IDLE, grant the port != last_owner. After reset, port 0 wins the first tie. A single requester always wins.
- Undefined: fixed priority; port 0 always wins ties; port 1 is granted only when req0=0 in IDLE. last_owner is still maintained but does not affect the decision.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding: IDLE=2'b00, ISSUE=2'b01, RESP=2'b10;
  - port index constants PORT_CPU=0, PORT_DMA=1;
  - default widths ADDR_W/DATA_W.
- One small combinational sub-module, mem_arb_pick: inputs req0, req1, last_owner; outputs valid and winner. It contains the policy and the MEM_ARB_ROUND_ROBIN_EN switch.
- The FSM and registers stay in mem_port_arbiter.

Test Plan:
- Port 0 write addr 0x10 data 0xA5 at cycle 0 -> gnt0=1, mem_memwrite=1, mem_address=0x10, mem_writedata=0xA5 in cycle 1; busy=0 in cycle 2. Then port 0 read 0x10 -> rvalid0=1, rdata0=0xA5 two cycles after the request; rvalid1 stays 0.
- req0 and req1 reads held high for 4 transactions (mem preloaded [0x01]=0x11, [0x02]=0x22) -> with RR_EN, grant order 0,1,0,1; without it, order 0,0,0,0 and gnt1 never asserts.
- rst driven low during ISSUE of a port 1 read -> all outputs 0 immediately, no rvalid1 after release, state IDLE, next tie grants port 0.
- req1 pulsed high for half a cycle between edges, never high at a rising edge in IDLE -> no gnt1, no memory access, busy stays 0.
- req0 write 0x3C to 0x20 and req1 read 0x20 requested simultaneously -> write first (port 0 priority / RR after reset), then rvalid1 with rdata1=0x3C.
- Port 0 held requesting 3 consecutive reads -> gnt0 every 3 cycles, one rvalid0 per read, never two transactions overlap.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter:
//   - state_t    : arbiter FSM encoding (IDLE / ISSUE / RESP)
//   - PORT_CPU   : index of the CPU load/store requester
//   - PORT_DMA   : index of the DMA / program-loader requester
//   - ADDR_W_DEF : default memory address width
//   - DATA_W_DEF : default memory data width
// No ports; imported with "import mem_arb_pkg::*;".
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles both requester ports and the memory-side bus of the arbiter.
//
// Handshake (both requester ports):
//   A requester raises reqN with weN/addrN/wdataN and holds all of them stable
//   until gntN pulses for one cycle; the request is accepted in that cycle.
//   Dropping reqN before the arbiter samples it in IDLE withdraws it. For a
//   read, rvalidN pulses exactly one cycle after gntN with rdataN valid in
//   that cycle only; rdataN is 0 at all other times.
//
// Modports:
//   slave  : arbiter side (requests/readdata in, grants/memory controls out)
//   master : environment side (requesters + memory), the mirror image
// Parameters: ADDR_W, DATA_W.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    // port 0 (CPU)
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    // port 1 (DMA / loader)
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    // memory side
    logic              mem_memread;
    logic              mem_memwrite;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;

    logic              busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_readdata,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_memread, mem_memwrite, mem_address, mem_writedata,
        output busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_readdata,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_memread, mem_memwrite, mem_address, mem_writedata,
        input  busy
    );

endinterface : mem_port_arbiter_if

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational arbitration policy for the two requesters.
//   req0, req1 : live requests
//   last_owner : port granted most recently
//   valid      : at least one request present
//   winner     : port index to grant (meaningful only when valid)
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   -> on a tie grant the port that did not win last time
//   undefined -> fixed priority, port 0 always wins a tie
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic valid,
    output logic winner
);

    assign valid = req0 | req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = ~last_owner;
        end else if (req1) begin
            winner = PORT_DMA;
        end
    end
`else
    // last_owner is kept by the FSM but plays no role under fixed priority.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        winner = PORT_CPU;
        if (!req0 && req1) begin
            winner = PORT_DMA;
        end
    end
`endif

endmodule : mem_arb_pick

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Serialises two requesters (port 0 = CPU, port 1 = DMA/loader) onto a single
// port synchronous-read memory and routes read data back to the requester.
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : mem_port_arbiter_if.slave (requester ports + memory bus + busy)
//   dbg_state : current FSM state, for observation only
// Parameters: ADDR_W, DATA_W.
// Configuration macro: MEM_ARB_ROUND_ROBIN_EN (selects tie-break policy, see
// mem_arb_pick).
//
// Timing: request sampled in IDLE -> ISSUE (gnt, memory strobe) -> for reads
// RESP (rvalid, memory's registered readdata). All memory-side outputs come
// from the state and latched registers only.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output state_t              dbg_state
);

    state_t            state;
    state_t            state_next;
    logic              owner;
    logic              last_owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              pick_valid;
    logic              pick_winner;
    logic              load;

    mem_arb_pick u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // next-state logic
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = ISSUE;
                    load       = 1'b1;
                end
            end
            ISSUE: begin
                // writes retire at the end of ISSUE; reads wait one cycle
                // for the memory's registered readdata
                state_next = lat_we ? IDLE : RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latched transaction; last_owner resets to port 1 so that port 0 wins the
    // first tie under round-robin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= PORT_CPU;
            last_owner <= PORT_DMA;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (load) begin
            owner      <= pick_winner;
            last_owner <= pick_winner;
            if (pick_winner == PORT_DMA) begin
                lat_we    <= bus.we1;
                lat_addr  <= bus.addr1;
                lat_wdata <= bus.wdata1;
            end else begin
                lat_we    <= bus.we0;
                lat_addr  <= bus.addr0;
                lat_wdata <= bus.wdata0;
            end
        end
    end

    logic in_issue;
    logic in_resp;

    assign in_issue = (state == ISSUE);
    assign in_resp  = (state == RESP);

    // memory side
    assign bus.mem_memwrite  = in_issue &  lat_we;
    assign bus.mem_memread   = in_issue & ~lat_we;
    assign bus.mem_address   = lat_addr;
    assign bus.mem_writedata = lat_wdata;

    // requester side
    assign bus.gnt0    = in_issue & (owner == PORT_CPU);
    assign bus.gnt1    = in_issue & (owner == PORT_DMA);
    assign bus.rvalid0 = in_resp  & (owner == PORT_CPU);
    assign bus.rvalid1 = in_resp  & (owner == PORT_DMA);
    assign bus.rdata0  = bus.rvalid0 ? bus.mem_readdata : '0;
    assign bus.rdata1  = bus.rvalid1 ? bus.mem_readdata : '0;

    assign bus.busy  = (state != IDLE);
    assign dbg_state = state;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a small synchronous-read memory
// model behind the arbiter. Expected tie-break order follows
// MEM_ARB_ROUND_ROBIN_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: registered read, write on memwrite
    logic [DATA_W-1:0] mem [256];

    always @(posedge clk) begin
        if (bus.mem_memwrite) mem[bus.mem_address] <= bus.mem_writedata;
        if (bus.mem_memread)  bus.mem_readdata     <= mem[bus.mem_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"},    bus.gnt0, 0);
        check({tag, "_gnt1"},    bus.gnt1, 0);
        check({tag, "_rvalid0"}, bus.rvalid0, 0);
        check({tag, "_rvalid1"}, bus.rvalid1, 0);
        check({tag, "_rdata0"},  bus.rdata0, 0);
        check({tag, "_rdata1"},  bus.rdata1, 0);
        check({tag, "_memrd"},   bus.mem_memread, 0);
        check({tag, "_memwr"},   bus.mem_memwrite, 0);
        check({tag, "_addr"},    bus.mem_address, 0);
        check({tag, "_wdata"},   bus.mem_writedata, 0);
        check({tag, "_busy"},    bus.busy, 0);
        check({tag, "_state"},   dbg_state, IDLE);
    endtask

    logic exp_port [4];
    logic p;

    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h01] = 8'h11;
        mem[8'h02] = 8'h22;
        bus.mem_readdata = '0;

        // reset state
        rst = 1'b0;
        clear_inputs();
        #2;
        check_all_zero("reset");
        do_reset();
        check_all_zero("post_reset");

        // port 0 write 0x10 <- 0xA5
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h10; bus.wdata0 = 8'hA5;
        step();
        check("wr_gnt0",  bus.gnt0, 1);
        check("wr_gnt1",  bus.gnt1, 0);
        check("wr_memwr", bus.mem_memwrite, 1);
        check("wr_memrd", bus.mem_memread, 0);
        check("wr_addr",  bus.mem_address, 8'h10);
        check("wr_data",  bus.mem_writedata, 8'hA5);
        check("wr_busy",  bus.busy, 1);
        bus.req0 = 1'b0;
        step();
        check("wr_done_busy",  bus.busy, 0);
        check("wr_done_memwr", bus.mem_memwrite, 0);
        check("wr_hold_addr",  bus.mem_address, 8'h10);

        // port 0 read 0x10
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        step();
        check("rd_gnt0",  bus.gnt0, 1);
        check("rd_memrd", bus.mem_memread, 1);
        check("rd_memwr", bus.mem_memwrite, 0);
        bus.req0 = 1'b0;
        step();
        check("rd_rvalid0", bus.rvalid0, 1);
        check("rd_rdata0",  bus.rdata0, 8'hA5);
        check("rd_rvalid1", bus.rvalid1, 0);
        check("rd_rdata1",  bus.rdata1, 0);
        check("rd_gnt0_off", bus.gnt0, 0);
        step();
        check("rd_done_busy",   bus.busy, 0);
        check("rd_done_rvalid", bus.rvalid0, 0);

        // both ports reading, held for 4 transactions
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h02;
        for (int t = 0; t < 4; t++) begin
            p = exp_port[t];
            step();
            check($sformatf("tie%0d_gnt0", t), bus.gnt0, {31'd0, ~p});
            check($sformatf("tie%0d_gnt1", t), bus.gnt1, {31'd0, p});
            step();
            check($sformatf("tie%0d_rvalid0", t), bus.rvalid0, {31'd0, ~p});
            check($sformatf("tie%0d_rvalid1", t), bus.rvalid1, {31'd0, p});
            check($sformatf("tie%0d_rdata0", t), bus.rdata0, p ? 32'h0 : 32'h11);
            check($sformatf("tie%0d_rdata1", t), bus.rdata1, p ? 32'h22 : 32'h0);
            step();
            check($sformatf("tie%0d_idle", t), bus.busy, 0);
        end
        clear_inputs();
        step();

        // reset during ISSUE of a port 1 read
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h02;
        step();
        check("rst_pre_gnt1", bus.gnt1, 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rst_issue");
        bus.req1 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        check("rst_no_rvalid1", bus.rvalid1, 0);
        check("rst_idle_busy",  bus.busy, 0);
        check("rst_idle_state", dbg_state, IDLE);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h02;
        step();
        check("rst_tie_gnt0", bus.gnt0, 1);
        check("rst_tie_gnt1", bus.gnt1, 0);
        clear_inputs();
        step();
        check("rst_tie_rvalid0", bus.rvalid0, 1);
        check("rst_tie_rdata0",  bus.rdata0, 8'h11);
        step();

        // req1 glitch between edges
        #2;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h05; bus.wdata1 = 8'hEE;
        #3;
        bus.req1 = 1'b0;
        step();
        check("glitch_gnt1",  bus.gnt1, 0);
        check("glitch_busy",  bus.busy, 0);
        check("glitch_memwr", bus.mem_memwrite, 0);
        check("glitch_memrd", bus.mem_memread, 0);
        step();
        check("glitch_busy2", bus.busy, 0);

        // simultaneous write (port 0) and read (port 1) of 0x20
        do_reset();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h20; bus.wdata0 = 8'h3C;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
        step();
        check("raw_gnt0",  bus.gnt0, 1);
        check("raw_gnt1",  bus.gnt1, 0);
        check("raw_memwr", bus.mem_memwrite, 1);
        bus.req0 = 1'b0;
        step();
        check("raw_idle", bus.busy, 0);
        step();
        check("raw_gnt1b", bus.gnt1, 1);
        check("raw_memrd", bus.mem_memread, 1);
        check("raw_addr",  bus.mem_address, 8'h20);
        bus.req1 = 1'b0;
        step();
        check("raw_rvalid1", bus.rvalid1, 1);
        check("raw_rdata1",  bus.rdata1, 8'h3C);
        check("raw_rvalid0", bus.rvalid0, 0);
        step();

        // port 0 held for 3 back-to-back reads
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        for (int t = 0; t < 3; t++) begin
            step();
            check($sformatf("b2b%0d_gnt0", t), bus.gnt0, 1);
            check($sformatf("b2b%0d_rv0_issue", t), bus.rvalid0, 0);
            step();
            check($sformatf("b2b%0d_rvalid0", t), bus.rvalid0, 1);
            check($sformatf("b2b%0d_rdata0", t), bus.rdata0, 8'hA5);
            check($sformatf("b2b%0d_gnt0_resp", t), bus.gnt0, 0);
            step();
            check($sformatf("b2b%0d_idle_gnt0", t), bus.gnt0, 0);
            check($sformatf("b2b%0d_idle_rv0", t), bus.rvalid0, 0);
        end
        clear_inputs();
        step();
        check("end_busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
